// File: rtl/rtc_mux_bus_ctrl_if.sv
// Host port and RTC strobe bundle for the multiplexed-bus RTC controller.
// Latency: none (wires only).
// Backpressure: none; the host polls busy/flag_done before issuing a new command.
interface rtc_mux_bus_ctrl_if #(
    parameter int DATA_W = 8
);
    logic [7:0]        port_id;
    logic [DATA_W-1:0] in_dato;
    logic              write_strobe;
    logic              read_strobe;
    logic [DATA_W-1:0] out_dato;
    logic              flag_done;
    logic              busy;
    logic              reg_a_d;
    logic              reg_cs;
    logic              reg_rd;
    logic              reg_wr;

    // master: the host that issues port accesses and watches status/strobes
    modport master (
        output port_id, in_dato, write_strobe, read_strobe,
        input  out_dato, flag_done, busy, reg_a_d, reg_cs, reg_rd, reg_wr
    );

    // slave: the controller that answers the host and drives the RTC strobes
    modport slave (
        input  port_id, in_dato, write_strobe, read_strobe,
        output out_dato, flag_done, busy, reg_a_d, reg_cs, reg_rd, reg_wr
    );
endinterface

// File: rtl/rtc_mux_bus_ctrl.sv
// Host-port controller that runs address/data bursts on a multiplexed RTC bus.
// Latency: flag_done 1+L*(T_ADDR+1+T_DATA+T_GAP) cycles after the command edge.
// Backpressure: commands arriving while busy are dropped and flagged as overrun.
module rtc_mux_bus_ctrl #(
    parameter int          DATA_W    = 8,
    parameter int          BURST_MAX = 8,
    parameter int          T_ADDR    = 4,
    parameter int          T_DATA    = 4,
    parameter int          T_GAP     = 4,
    parameter logic [7:0]  P_ADDR    = 8'h00,
    parameter logic [7:0]  P_WBUF    = 8'h10,
    parameter logic [7:0]  P_RBUF    = 8'h20,
    parameter logic [7:0]  P_CMD     = 8'h0E,
    parameter logic [7:0]  P_STAT    = 8'h0F
) (
    input  logic              clk,
    input  logic              reset,
    rtc_mux_bus_ctrl_if.slave bus,
    inout  wire [DATA_W-1:0]  dato
);
    localparam int         LEN_W  = $clog2(BURST_MAX);
    localparam int         CNT_W  = 8;
    localparam logic [8:0] WB_END = 9'(P_WBUF) + 9'(BURST_MAX);
    localparam logic [8:0] RB_END = 9'(P_RBUF) + 9'(BURST_MAX);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_ALH, S_DATA, S_GAP, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, plen_m1;
    logic [LEN_W-1:0]  k_q, k_d, len_q, len_d;
    logic              rd_q, rd_d;
    logic [DATA_W-1:0] addr_q, base_q, nxt_base, nxt_addr;
    logic [DATA_W-1:0] wbuf_q [BURST_MAX];
    logic [DATA_W-1:0] rbuf_q [BURST_MAX];
    logic              busy_q, flag_done_q, done_q, ovr_q;
    logic              reg_a_d_q, reg_cs_q, reg_rd_q, reg_wr_q;
    logic [DATA_W-1:0] dato_q, out_dato_q;
    logic              dato_oe_q;
    logic              wb_hit, rb_hit, cmd_wr, start, stat_rd, phase_end;
    logic [LEN_W-1:0]  wb_idx, rb_idx;

    assign wb_hit  = ({1'b0, bus.port_id} >= {1'b0, P_WBUF}) && ({1'b0, bus.port_id} < WB_END);
    assign rb_hit  = ({1'b0, bus.port_id} >= {1'b0, P_RBUF}) && ({1'b0, bus.port_id} < RB_END);
    assign wb_idx  = LEN_W'(bus.port_id - P_WBUF);
    assign rb_idx  = LEN_W'(bus.port_id - P_RBUF);
    assign cmd_wr  = bus.write_strobe && (bus.port_id == P_CMD);
    assign start   = cmd_wr && !busy_q;
    assign stat_rd = bus.read_strobe && (bus.port_id == P_STAT);
    assign rd_d    = start ? bus.in_dato[7] : rd_q;
    assign len_d   = start ? bus.in_dato[LEN_W-1:0] : len_q;

    // Phase length of the current state, minus one, for the cycle counter compare
    always_comb begin
        plen_m1 = '0;
        case (state_q)
            S_ADDR:  plen_m1 = CNT_W'(T_ADDR - 1);
            S_DATA:  plen_m1 = CNT_W'(T_DATA - 1);
            S_GAP:   plen_m1 = CNT_W'(T_GAP - 1);
            default: plen_m1 = '0;
        endcase
    end

    assign phase_end = (cnt_q == plen_m1);

    // Next-state logic: walk ADDR/ALH/DATA/GAP per byte, then DONE once
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = phase_end ? '0 : cnt_q + 1'b1;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                k_d   = '0;
                if (start) state_d = S_ADDR;
            end
            S_ADDR: if (phase_end) state_d = S_ALH;
            S_ALH:  if (phase_end) state_d = S_DATA;
            S_DATA: if (phase_end) state_d = S_GAP;
            S_GAP: begin
                if (phase_end) begin
                    if (k_q == len_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ADDR;
                        k_d     = k_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The burst base is only taken from the host register when a burst starts
    assign nxt_base = (state_q == S_IDLE) ? addr_q : base_q;
    assign nxt_addr = nxt_base + DATA_W'(k_d);

    // FSM state plus strobes/bus drive registered from the upcoming state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            k_q         <= '0;
            len_q       <= '0;
            rd_q        <= 1'b0;
            base_q      <= '0;
            busy_q      <= 1'b0;
            flag_done_q <= 1'b0;
            reg_a_d_q   <= 1'b1;
            reg_cs_q    <= 1'b1;
            reg_rd_q    <= 1'b1;
            reg_wr_q    <= 1'b1;
            dato_q      <= '0;
            dato_oe_q   <= 1'b0;
            for (int i = 0; i < BURST_MAX; i++) rbuf_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            k_q         <= k_d;
            len_q       <= len_d;
            rd_q        <= rd_d;
            if (start) base_q <= addr_q;
            busy_q      <= (state_d != S_IDLE);
            flag_done_q <= (state_d == S_DONE);
            reg_a_d_q   <= !(state_d == S_ADDR);
            reg_cs_q    <= !(state_d == S_ADDR || state_d == S_DATA);
            reg_wr_q    <= !(state_d == S_ADDR || (state_d == S_DATA && !rd_d));
            reg_rd_q    <= !(state_d == S_DATA && rd_d);
            dato_oe_q   <= (state_d == S_ADDR) || (state_d == S_ALH) ||
                           (state_d == S_DATA && !rd_d);
            dato_q      <= (state_d == S_DATA) ? wbuf_q[k_d] : nxt_addr;
            // Read data is captured at the end of the last DATA cycle
            if (state_q == S_DATA && rd_q && phase_end) rbuf_q[k_q] <= dato;
        end
    end

    // Host-visible registers: start address, write buffer, sticky status, read mux
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q     <= '0;
            done_q     <= 1'b0;
            ovr_q      <= 1'b0;
            out_dato_q <= '0;
            for (int i = 0; i < BURST_MAX; i++) wbuf_q[i] <= '0;
        end else begin
            if (bus.write_strobe && bus.port_id == P_ADDR) addr_q <= bus.in_dato;
            if (bus.write_strobe && wb_hit && !busy_q) wbuf_q[wb_idx] <= bus.in_dato;
            if (state_d == S_DONE) done_q <= 1'b1;
            else if (stat_rd)      done_q <= 1'b0;
            if (cmd_wr && busy_q)  ovr_q  <= 1'b1;
            else if (stat_rd)      ovr_q  <= 1'b0;
            if (bus.port_id == P_STAT)      out_dato_q <= DATA_W'({ovr_q, done_q, busy_q});
            else if (rb_hit)                out_dato_q <= rbuf_q[rb_idx];
            else if (bus.port_id == P_ADDR) out_dato_q <= addr_q;
            else                            out_dato_q <= '0;
        end
    end

    assign dato          = dato_oe_q ? dato_q : {DATA_W{1'bz}};
    assign bus.out_dato  = out_dato_q;
    assign bus.flag_done = flag_done_q;
    assign bus.busy      = busy_q;
    assign bus.reg_a_d   = reg_a_d_q;
    assign bus.reg_cs    = reg_cs_q;
    assign bus.reg_rd    = reg_rd_q;
    assign bus.reg_wr    = reg_wr_q;
endmodule

// File: doc/rtc_mux_bus_ctrl.md
RTC_MUX_BUS_CTRL -- requirements
Module: rtc_mux_bus_ctrl

Interface
Parameters (name, default, meaning):
REQ-001 SHALL have DATA_W, 8: width of the host data path and of the multiplexed RTC address/data bus.
REQ-002 SHALL have BURST_MAX, 8: depth of the write and read buffers, a power of two from 2 to 16; LEN_W = log2(BURST_MAX).
REQ-003 SHALL have T_ADDR, 4: cycles the address phase lasts (≥1).
REQ-004 SHALL have T_DATA, 4: cycles the data phase lasts (≥2).
REQ-005 SHALL have T_GAP, 4: idle cycles after each byte (≥1).
REQ-006 SHALL have P_ADDR 8'h00, P_WBUF 8'h10, P_RBUF 8'h20, P_CMD 8'h0E, P_STAT 8'h0F: host port map; the WBUF and RBUF windows are BURST_MAX entries each.
Ports (name, direction, width, meaning):
REQ-007 SHALL have clk, in, 1: the single clock; every register updates on its rising edge.
REQ-008 SHALL have reset, in, 1: synchronous, active-high.
REQ-009 SHALL have port_id in 8, in_dato in DATA_W, write_strobe in 1, read_strobe in 1: host port interface.
REQ-010 SHALL have out_dato, out, DATA_W: registered host read data.
REQ-011 SHALL have flag_done, out, 1: one-cycle pulse when a transaction completes.
REQ-012 SHALL have busy, out, 1: high while a transaction is in progress.
REQ-013 SHALL have reg_a_d, reg_cs, reg_rd, reg_wr, each out, 1: RTC bus strobes, all active-low.
REQ-014 SHALL have dato, inout, DATA_W: multiplexed RTC address/data bus.

Function
REQ-015 SHALL, on write_strobe with port_id==P_ADDR, latch in_dato as the start address; with port_id==P_WBUF+i, write wbuf[i].
REQ-016 SHALL, on write_strobe with port_id==P_CMD while idle, start a transaction:
- in_dato[7]=1 is a read, 0 is a write.
- Burst length is in_dato[LEN_W-1:0]+1.
REQ-017 SHALL ignore a P_CMD write while busy=1, set sticky status bit ovr, and leave the transaction in progress unchanged.
REQ-018 SHALL use FSM states IDLE→ADDR→ALH→DATA→GAP, then back to ADDR if bytes remain, else DONE→IDLE.
REQ-019 SHALL enter ADDR on the cycle after the command strobe edge, with busy=1 from that same cycle.
REQ-020 SHALL, in ADDR (T_ADDR cycles), hold reg_a_d=0, reg_cs=0, reg_wr=0, reg_rd=1, and drive dato=(start+k) mod 2^DATA_W, where k is the byte index.
REQ-021 SHALL, in ALH (1 cycle), hold all strobes high and keep dato at the address value (hold time).
REQ-022 SHALL, in DATA (T_DATA cycles), hold reg_cs=0:
- Write: reg_wr=0 and dato=wbuf[k].
- Read: reg_rd=0 and dato tri-stated; dato is sampled into rbuf[k] on the last DATA cycle.
REQ-023 SHALL, in GAP (T_GAP cycles), hold all strobes high and tri-state dato.
REQ-024 SHALL, in DONE (1 cycle), pulse flag_done=1, set sticky status bit done, and drop busy to 0 in the following IDLE cycle.
REQ-025 SHALL assert flag_done exactly 1+L*(T_ADDR+1+T_DATA+T_GAP) cycles after the command strobe edge, for burst length L.
REQ-026 SHALL never assert reg_rd=0 and reg_wr=0 together, and SHALL never drive dato while reg_rd=0.
REQ-027 SHALL register out_dato one cycle after port_id:
- P_STAT gives {0…, ovr, done, busy}.
- P_RBUF+i gives rbuf[i].
- P_ADDR gives the start address.
- Any other port gives 0.
REQ-028 SHALL clear done and ovr in the cycle after a read_strobe with port_id==P_STAT; a set event in that same cycle has priority over the clear.
REQ-029 SHALL ignore host writes to wbuf while busy=1; the buffer contents stay stable during a burst.
REQ-030 SHALL ignore write_strobe and read_strobe to unmapped port_ids.

Reset
REQ-031 SHALL, on reset=1 at a clock edge, including mid-transaction:
- Go to IDLE.
- Set reg_a_d=reg_cs=reg_rd=reg_wr=1 and tri-state dato.
- Clear busy, flag_done, done, ovr, out_dato, the start address, wbuf and rbuf to 0.
REQ-032 SHALL take no RTC bus action until the first P_CMD write after reset is deasserted.

Verification
REQ-033 SHALL pass single write:
- Stimulus: ADDR=0x21, WBUF0=0x01, CMD=0x00.
- Response: dato=0x21 with reg_a_d=0 for 4 cycles, then reg_wr=0 with dato=0x01 for 4 cycles; flag_done 14 cycles after the CMD edge; STAT reads 0x02.
REQ-034 SHALL pass burst read:
- Stimulus: ADDR=0xFE, CMD=0x82, RTC model returns 0x11/0x22/0x33.
- Response: address phases show 0xFE, 0xFF, 0x00 (wrap); RBUF0..2=0x11, 0x22, 0x33; flag_done at cycle 40.
REQ-035 SHALL pass overrun:
- Stimulus: a second CMD write during a burst.
- Response: the burst completes unchanged; STAT=0x06, then 0x00 after the status read.
REQ-036 SHALL pass reset mid-DATA of a write:
- Response: the next cycle has all strobes high, dato=Z and busy=0; no flag_done.
REQ-037 SHALL pass the bus-exclusion checker:
- Check: reg_rd and reg_wr are never both 0, and dato is never driven while reg_rd=0.
- Run: across randomized bursts with T_ADDR=1, T_DATA=2, T_GAP=1.
